// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
//   Multi-ported register file: two registered read ports and one write port.
//   After reset a CLEAR sequence walks every entry and writes zero, one entry
//   per clock. It then moves to RUN, where normal reads and writes take place.
//   The array itself has no reset; the clear sequence is what zeroes it.
//
// Parameters
//   DATA_W    : register width in bits
//   ADDR_W    : address width, depth = 2**ADDR_W entries
//   ZERO_REG0 : when 1, entry 0 is hardwired to zero
//
// Ports
//   clk                : clock, all state changes on its rising edge
//   rst_n              : synchronous active-low reset
//   rd_addr1/rd_addr2  : read port addresses
//   rd_data1/rd_data2  : registered read data, one-cycle latency
//   wr_en              : write request, ignored while clearing
//   wr_addr/wr_data    : write address and data
//   busy               : high while the clear sequence runs
//
// Configuration
//   REGFILE_BYPASS_EN  : when defined, a same-cycle write to the entry being
//                        read is forwarded to the read data register.
//                        When undefined, a read returns the pre-write value.
// ---------------------------------------------------------------------------
module reg_file_mp #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned ZERO_REG0 = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clear_ptr;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                wr_zero_c;
    logic                rd1_zero_c;
    logic                rd2_zero_c;
    logic                mem_we_c;
    logic [ADDR_W-1:0]   mem_waddr_c;
    logic [DATA_W-1:0]   mem_wdata_c;
    logic [DATA_W-1:0]   rd1_next_c;
    logic [DATA_W-1:0]   rd2_next_c;

    // Hardwired-zero address decode
    always_comb begin
        wr_zero_c  = 1'b0;
        rd1_zero_c = 1'b0;
        rd2_zero_c = 1'b0;
        if (ZERO_REG0 != 0) begin
            wr_zero_c  = (wr_addr  == '0);
            rd1_zero_c = (rd_addr1 == '0);
            rd2_zero_c = (rd_addr2 == '0);
        end
    end

    // Array write port: clear walker in CLEAR, user write in RUN
    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = wr_addr;
        mem_wdata_c = wr_data;
        if (rst_n) begin
            if (state == ST_CLEAR) begin
                mem_we_c    = 1'b1;
                mem_waddr_c = clear_ptr;
                mem_wdata_c = '0;
            end else begin
                mem_we_c = wr_en && !wr_zero_c;
            end
        end
    end

    // Next read data for RUN; optional write-to-read forwarding
    always_comb begin
        rd1_next_c = rd1_zero_c ? '0 : mem[rd_addr1];
        rd2_next_c = rd2_zero_c ? '0 : mem[rd_addr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr1) && !rd1_zero_c) begin
            rd1_next_c = wr_data;
        end
        if (wr_en && (wr_addr == rd_addr2) && !rd2_zero_c) begin
            rd2_next_c = wr_data;
        end
`endif
    end

    // Storage array, deliberately without reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Control FSM with registered busy and read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_CLEAR;
            clear_ptr <= '0;
            busy      <= 1'b1;
            rd_data1  <= '0;
            rd_data2  <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    rd_data1 <= '0;
                    rd_data2 <= '0;
                    if (&clear_ptr) begin
                        // Last entry cleared this edge; pointer returns to 0 only here
                        state     <= ST_RUN;
                        busy      <= 1'b0;
                        clear_ptr <= '0;
                    end else begin
                        clear_ptr <= clear_ptr + ADDR_W'(1);
                    end
                end
                ST_RUN: begin
                    rd_data1 <= rd1_next_c;
                    rd_data2 <= rd2_next_c;
                end
                default: begin
                    state <= ST_CLEAR;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp
//   Self-checking bench for reg_file_mp (DATA_W=32, ADDR_W=5, ZERO_REG0=1).
//   Each applied cycle pushes its expected outputs to a scoreboard queue; the
//   entry is popped and compared one time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic [ADDR_W-1:0] rd_addr1 = '0;
    logic [ADDR_W-1:0] rd_addr2 = '0;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              busy;

    always #5 clk = ~clk;

    reg_file_mp #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG0(1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_addr1(rd_addr1),
        .rd_addr2(rd_addr2),
        .rd_data1(rd_data1),
        .rd_data2(rd_data2),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    typedef struct {
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
        logic              eb;
        string             nm;
    } exp_t;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic [ADDR_W-1:0] a1;
        logic [ADDR_W-1:0] a2;
        logic [DATA_W-1:0] x1;
        logic [DATA_W-1:0] x2;
        string             nm;
    } vec_t;

    exp_t              sb[$];
    vec_t              tbl[10];
    int                n_vec = 0;
    int                n_err = 0;

    // Reference model state
    logic [DATA_W-1:0] mdl [DEPTH];
    bit                m_clear = 1'b1;
    int                m_ptr = 0;

    function automatic logic [DATA_W-1:0] mdl_rd(input logic [ADDR_W-1:0] a);
        return (a == '0) ? '0 : mdl[a];
    endfunction

    task automatic model_step(input logic r, input logic we, input logic [ADDR_W-1:0] wa,
                              input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] a1,
                              input logic [ADDR_W-1:0] a2, output logic [DATA_W-1:0] e1,
                              output logic [DATA_W-1:0] e2, output logic eb);
        if (!r) begin
            e1 = '0; e2 = '0; eb = 1'b1;
            m_clear = 1'b1; m_ptr = 0;
        end else if (m_clear) begin
            e1 = '0; e2 = '0;
            mdl[ADDR_W'(m_ptr)] = '0;
            m_ptr++;
            if (m_ptr == DEPTH) begin
                m_clear = 1'b0; m_ptr = 0; eb = 1'b0;
            end else begin
                eb = 1'b1;
            end
        end else begin
            e1 = mdl_rd(a1);
            e2 = mdl_rd(a2);
            if (BYP && we && wa == a1 && wa != '0) e1 = wd;
            if (BYP && we && wa == a2 && wa != '0) e2 = wd;
            if (we && wa != '0) mdl[wa] = wd;
            eb = 1'b0;
        end
    endtask

    task automatic cmp(input string nm, input string fld, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s.%s: got 0x%08h, required 0x%08h", nm, fld, act, req);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard: got empty queue, required one entry");
            return;
        end
        e = sb.pop_front();
        cmp(e.nm, "rd_data1", rd_data1, e.e1);
        cmp(e.nm, "rd_data2", rd_data2, e.e2);
        cmp(e.nm, "busy", DATA_W'(busy), DATA_W'(e.eb));
    endtask

    // Drive one cycle, queue expectation (table constants or model), check after edge
    task automatic apply(input logic r, input logic we, input logic [ADDR_W-1:0] wa,
                         input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] a1,
                         input logic [ADDR_W-1:0] a2, input bit use_tbl,
                         input logic [DATA_W-1:0] t1, input logic [DATA_W-1:0] t2,
                         input string nm);
        exp_t e;
        logic [DATA_W-1:0] m1, m2;
        logic mb;
        rst_n = r; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr1 = a1; rd_addr2 = a2;
        model_step(r, we, wa, wd, a1, a2, m1, m2, mb);
        e.e1 = use_tbl ? t1 : m1;
        e.e2 = use_tbl ? t2 : m2;
        e.eb = use_tbl ? 1'b0 : mb;
        e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    // Count edges after reset release until busy falls (bounded)
    task automatic count_busy(input logic we, input logic [ADDR_W-1:0] wa,
                              input logic [DATA_W-1:0] wd, output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            apply(1'b1, we, wa, wd, 5'd4, 5'd9, 1'b0, '0, '0, "clear");
            n++;
            if (!busy) break;
        end
    endtask

    task automatic cmp_busy_len(input string nm, input int n);
        n_vec++;
        if (n != 32) begin
            n_err++;
            $display("FAIL %s: busy lasted %0d cycles, required 32", nm, n);
        end
    endtask

    initial begin
        int n;

        tbl[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0, 32'h0, "wr7"};
        tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd4,  32'hDEADBEEF, 32'h0, "rd7_rd4"};
        tbl[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0, 32'h0, "wr0"};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0, "rd0_both"};
        tbl[4] = '{1'b1, 5'd3,  32'hA5A5A5A5, 5'd7,  5'd3,  32'hDEADBEEF,
                   BYP ? 32'hA5A5A5A5 : 32'h0, "wr3_rd3_same"};
        tbl[5] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'hA5A5A5A5, 32'hA5A5A5A5, "rd3_both"};
        tbl[6] = '{1'b1, 5'd9,  32'h55,       5'd9,  5'd31, BYP ? 32'h55 : 32'h0, 32'h0, "wr9"};
        tbl[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd9,  BYP ? 32'hFFFFFFFF : 32'h0,
                   32'h55, "wr31"};
        tbl[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd9,  32'hFFFFFFFF, 32'h55, "rd31_rd9"};
        tbl[9] = '{1'b1, 5'd5,  32'h1,        5'd5,  5'd5,  BYP ? 32'h1 : 32'h0,
                   BYP ? 32'h1 : 32'h0, "wr5_rd5_both"};

        // Reset for two cycles, then clear with a write attempted to entry 4
        apply(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0, '0, "reset0");
        apply(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0, '0, "reset1");
        count_busy(1'b1, 5'd4, 32'hFF, n);
        cmp_busy_len("busy_len_initial", n);

        for (int i = 0; i < 10; i++) begin
            apply(1'b1, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].a1, tbl[i].a2,
                  1'b1, tbl[i].x1, tbl[i].x2, tbl[i].nm);
        end

        // Reset pulse in RUN: full clear restarts and wipes entry 9
        apply(1'b0, 1'b0, '0, '0, 5'd9, 5'd9, 1'b0, '0, '0, "reset_run");
        count_busy(1'b0, '0, '0, n);
        cmp_busy_len("busy_len_after_run_reset", n);
        apply(1'b1, 1'b0, '0, '0, 5'd9, 5'd7, 1'b1, 32'h0, 32'h0, "rd9_after_reset");
        apply(1'b1, 1'b0, '0, '0, 5'd31, 5'd3, 1'b1, 32'h0, 32'h0, "rd31_after_reset");

        // Reset part-way through CLEAR restarts from entry 0
        apply(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0, '0, "reset_pre");
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 1'b1, 5'd6, 32'h77, 5'd6, 5'd1, 1'b0, '0, '0, "part_clear");
        end
        apply(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0, '0, "reset_mid_clear");
        count_busy(1'b0, '0, '0, n);
        cmp_busy_len("busy_len_after_mid_clear_reset", n);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            apply(1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)),
                  DATA_W'($urandom), ADDR_W'($urandom_range(0, 31)),
                  ADDR_W'($urandom_range(0, 31)), 1'b0, '0, '0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; depth is 2^ADDR_W entries.
REQ-003 The block SHALL have parameter ZERO_REG0, default 1; when 1, entry 0 is hardwired zero.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 The block SHALL have port rd_addr1, input, ADDR_W, read port 1 address.
REQ-007 The block SHALL have port rd_addr2, input, ADDR_W, read port 2 address.
REQ-008 The block SHALL have port rd_data1, output, DATA_W, registered read port 1 data.
REQ-009 The block SHALL have port rd_data2, output, DATA_W, registered read port 2 data.
REQ-010 The block SHALL have port wr_en, input, 1, write request, qualified by the RUN state.
REQ-011 The block SHALL have port wr_addr, input, ADDR_W, write address.
REQ-012 The block SHALL have port wr_data, input, DATA_W, write data.
REQ-013 The block SHALL have port busy, output, 1, high while the clear sequence runs.

Function
REQ-014 The block SHALL implement a two-state FSM, CLEAR and RUN, with a clear pointer of ADDR_W bits.
REQ-015 In CLEAR, each rising edge SHALL write zero to entry[clear_ptr] and increment clear_ptr.
REQ-016 After clearing entry 2^ADDR_W-1, the FSM SHALL move to RUN on that same edge.
REQ-017 As a result, busy SHALL be high for exactly 2^ADDR_W cycles after rst_n deasserts, then low.
REQ-018 In CLEAR, wr_en SHALL be ignored and the write dropped, with no queuing.
REQ-019 In CLEAR, rd_data1 and rd_data2 SHALL be loaded with zero every cycle.
REQ-020 In RUN, wr_en=1 SHALL write wr_data to entry[wr_addr] on the rising edge.
REQ-021 In RUN, each rd_dataN SHALL be loaded on the rising edge with entry[rd_addrN] as sampled at that edge.
REQ-022 Read latency SHALL be one cycle.
REQ-023 Both read ports SHALL operate independently and may address the same entry in the same cycle.
REQ-024 When ZERO_REG0=1, writes to address 0 SHALL be discarded and reads of address 0 SHALL return zero.
REQ-025 When ZERO_REG0=0, entry 0 SHALL behave like any other entry.
REQ-026 The clear pointer SHALL wrap from 2^ADDR_W-1 to 0 only via the CLEAR-to-RUN exit, never by continuing to clear.

Reset
REQ-027 While rst_n=0 at a rising edge, the block SHALL set state=CLEAR, clear_ptr=0, busy=1, rd_data1=0, rd_data2=0.
REQ-028 Array contents SHALL NOT be reset directly; they are zeroed by the clear sequence.
REQ-029 rst_n asserted mid-clear or mid-RUN SHALL restart the clear sequence from entry 0.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN defined: in RUN, when wr_en=1, wr_addr==rd_addrN, and the address is not a hardwired-zero entry, rd_dataN SHALL load wr_data on the same edge.
REQ-031 Macro REGFILE_BYPASS_EN undefined: rd_dataN SHALL load the pre-write entry value; the new value is visible one cycle later.

Verification
REQ-032 Reset scenario: DATA_W=32, ADDR_W=5, rst_n low for 2 cycles then high -> busy=1 for exactly 32 cycles, then 0; rd_data1 and rd_data2 = 0 throughout.
REQ-033 Write/read scenario: in RUN, write 0xDEADBEEF to entry 7, then read rd_addr1=7 on the next cycle -> rd_data1=0xDEADBEEF one cycle later.
REQ-034 Zero-register scenario: ZERO_REG0=1, write 0x12345678 to entry 0, then read entry 0 on both ports -> both ports read 0.
REQ-035 Same-cycle scenario: write 0xA5A5A5A5 to entry 3 while rd_addr2=3 -> rd_data2=0xA5A5A5A5 with REGFILE_BYPASS_EN, old value 0x0 without it.
REQ-036 Mid-clear scenario: wr_en=1 with wr_addr=4 and wr_data=0xFF during CLEAR -> entry 4 reads 0 after busy falls.
REQ-037 Reset-mid-operation scenario: write entry 9 = 0x55 in RUN, then pulse rst_n low for 1 cycle -> busy=1 for 32 cycles and entry 9 reads 0 afterwards.
